// File: rtl/dmem_stream_responder.sv
// Data-memory responder for the E/M-stage bus: a scratch RAM plus memory-mapped
// input (source -> CPU) and output (CPU -> sink) audio sample FIFOs.
module dmem_stream_responder #(
    parameter int unsigned RAM_WORDS  = 256,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned SAMPLE_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemWriteE,
    input  logic                MemReadE,
    input  logic [31:0]         ALUOutE,
    input  logic [31:0]         WriteDataE,
    output logic [31:0]         ReadDataM,
    input  logic [SAMPLE_W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [SAMPLE_W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int unsigned RAW = $clog2(RAM_WORDS);
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = PW + 1;

    localparam logic [29:0] WordInData  = 30'h0000_4000;
    localparam logic [29:0] WordOutData = 30'h0000_4001;
    localparam logic [29:0] WordStatus  = 30'h0000_4002;

    // Storage
    logic [31:0]         ram_q     [RAM_WORDS];
    logic [SAMPLE_W-1:0] in_mem_q  [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] out_mem_q [FIFO_DEPTH];

    // Pointers, counts, stickies, load register
    logic [PW-1:0] in_wr_ptr_q, in_rd_ptr_q, out_wr_ptr_q, out_rd_ptr_q;
    logic [CW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic          ovf_q, ovf_d, und_q, und_d;
    logic [31:0]   rdata_q;

    // Address decode and strobes
    logic           ram_sel, in_sel, out_sel, stat_sel;
    logic           wr_en, rd_en;
    logic [RAW-1:0] ram_idx;
    logic           unused_addr;

    assign ram_sel     = (ALUOutE[31:RAW+2] == '0);
    assign ram_idx     = ALUOutE[RAW+1:2];
    assign in_sel      = (ALUOutE[31:2] == WordInData);
    assign out_sel     = (ALUOutE[31:2] == WordOutData);
    assign stat_sel    = (ALUOutE[31:2] == WordStatus);
    assign unused_addr = ^ALUOutE[1:0];

    // A simultaneous store wins: the load is dropped and ReadDataM holds.
    assign wr_en = MemWriteE;
    assign rd_en = MemReadE && !MemWriteE;

    // FIFO flags and handshakes
    logic in_empty, in_full, out_empty, out_full;
    logic in_push, in_pop, out_push, out_pop;
    logic ovf_set, ovf_clr, und_set, und_clr;

    assign in_empty  = (in_cnt_q == '0);
    assign in_full   = (in_cnt_q == CW'(FIFO_DEPTH));
    assign out_empty = (out_cnt_q == '0);
    assign out_full  = (out_cnt_q == CW'(FIFO_DEPTH));

    assign in_ready  = !in_full && !reset;
    assign in_push   = in_valid && in_ready;
    assign in_pop    = rd_en && in_sel && !in_empty;
    assign und_set   = rd_en && in_sel && in_empty;

    assign out_valid = !out_empty;
    assign out_data  = out_mem_q[out_rd_ptr_q];
    assign out_pop   = out_valid && out_ready;
    // Fullness is judged on the pre-edge count, so a same-cycle sink pop does not help.
    assign out_push  = wr_en && out_sel && !out_full;
    assign ovf_set   = wr_en && out_sel && out_full;

    assign ovf_clr   = wr_en && stat_sel && WriteDataE[4];
    assign und_clr   = wr_en && stat_sel && WriteDataE[5];

    assign ReadDataM = rdata_q;

    // Next-state for counts and sticky flags (set beats clear)
    always_comb begin
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        if (in_push && !in_pop) begin
            in_cnt_d = in_cnt_q + CW'(1);
        end else if (!in_push && in_pop) begin
            in_cnt_d = in_cnt_q - CW'(1);
        end
        if (out_push && !out_pop) begin
            out_cnt_d = out_cnt_q + CW'(1);
        end else if (!out_push && out_pop) begin
            out_cnt_d = out_cnt_q - CW'(1);
        end
        ovf_d = ovf_set | (ovf_q & ~ovf_clr);
        und_d = und_set | (und_q & ~und_clr);
    end

    // Load data mux: decoded read value captured into ReadDataM on a load
    logic [31:0] status;
    logic [31:0] rd_data;

    assign status = {8'h00, 8'(out_cnt_q), 8'(in_cnt_q), 2'b00, und_q, ovf_q,
                     out_full, out_empty, in_full, in_empty};

    always_comb begin
        rd_data = '0;
        if (ram_sel) begin
            rd_data = ram_q[ram_idx];
        end else if (in_sel) begin
            if (!in_empty) begin
                rd_data = 32'(signed'(in_mem_q[in_rd_ptr_q]));
            end
        end else if (stat_sel) begin
            rd_data = status;
        end
    end

    // Control state: pointers, counts, stickies and the M-stage load register
    always_ff @(posedge clk) begin
        if (reset) begin
            in_wr_ptr_q  <= '0;
            in_rd_ptr_q  <= '0;
            out_wr_ptr_q <= '0;
            out_rd_ptr_q <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            und_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            if (in_push)  in_wr_ptr_q  <= in_wr_ptr_q + PW'(1);
            if (in_pop)   in_rd_ptr_q  <= in_rd_ptr_q + PW'(1);
            if (out_push) out_wr_ptr_q <= out_wr_ptr_q + PW'(1);
            if (out_pop)  out_rd_ptr_q <= out_rd_ptr_q + PW'(1);
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            ovf_q     <= ovf_d;
            und_q     <= und_d;
            if (rd_en) rdata_q <= rd_data;
        end
    end

    // Storage writes; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en && ram_sel) ram_q[ram_idx] <= WriteDataE;
        if (in_push)  in_mem_q[in_wr_ptr_q]   <= in_data;
        if (out_push) out_mem_q[out_wr_ptr_q] <= WriteDataE[SAMPLE_W-1:0];
    end

endmodule

// File: tb/tb_dmem_stream_responder.sv
// Self-checking bench for dmem_stream_responder: queue-based reference model
// with a load-data scoreboard and an output-sample scoreboard.
module tb_dmem_stream_responder;

    localparam int unsigned RW = 256;
    localparam int unsigned FD = 16;
    localparam int unsigned SW = 16;

    localparam logic [31:0] AIn  = 32'h0001_0000;
    localparam logic [31:0] AOut = 32'h0001_0004;
    localparam logic [31:0] ASt  = 32'h0001_0008;

    logic          clk, reset, MemWriteE, MemReadE;
    logic [31:0]   ALUOutE, WriteDataE, ReadDataM;
    logic [SW-1:0] in_data, out_data;
    logic          in_valid, in_ready, out_valid, out_ready;

    int errors = 0;
    int checks = 0;

    logic [31:0]   ram_m [RW];
    logic [SW-1:0] in_m[$];
    logic [SW-1:0] out_m[$];
    logic [31:0]   rd_q[$];
    logic [31:0]   exp_rdm = '0;
    logic          ovf_m = 1'b0, und_m = 1'b0, rst_seen = 1'b0;

    dmem_stream_responder #(
        .RAM_WORDS (RW),
        .FIFO_DEPTH(FD),
        .SAMPLE_W  (SW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWriteE (MemWriteE),
        .MemReadE  (MemReadE),
        .ALUOutE   (ALUOutE),
        .WriteDataE(WriteDataE),
        .ReadDataM (ReadDataM),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_m();
        int unsigned ic = in_m.size();
        int unsigned oc = out_m.size();
        return {8'h00, oc[7:0], ic[7:0], 2'b00, und_m, ovf_m,
                oc == FD, oc == 0, ic == FD, ic == 0};
    endfunction

    // Evaluated mid-cycle: check outputs against the model, then advance the model
    task automatic model_eval();
        logic [31:0] v;
        logic rd, wr, ip, ipush, op, opush, oset, oclr, uset, uclr;
        check_eq("in_ready", in_ready, !reset && in_m.size() < FD);
        check_eq("out_valid", out_valid, out_m.size() != 0);
        if (out_m.size() != 0) check_eq("out_data", out_data, out_m[0]);
        if (reset) begin
            in_m.delete();
            out_m.delete();
            rd_q.delete();
            ovf_m = 1'b0;
            und_m = 1'b0;
            rst_seen = 1'b1;
            return;
        end
        rd = MemReadE && !MemWriteE;
        wr = MemWriteE;
        ip = 0; opush = 0; oset = 0; oclr = 0; uset = 0; uclr = 0;
        ipush = in_valid && (in_m.size() < FD);
        op = (out_m.size() != 0) && out_ready;
        if (rd) begin
            v = '0;
            if (ALUOutE < RW * 4) begin
                v = ram_m[ALUOutE[9:2]];
            end else if (ALUOutE[31:2] == AIn[31:2]) begin
                if (in_m.size() != 0) begin
                    v = {{(32-SW){in_m[0][SW-1]}}, in_m[0]};
                    ip = 1;
                end else begin
                    uset = 1;
                end
            end else if (ALUOutE[31:2] == ASt[31:2]) begin
                v = status_m();
            end
            rd_q.push_back(v);
        end
        if (wr) begin
            if (ALUOutE < RW * 4) begin
                ram_m[ALUOutE[9:2]] = WriteDataE;
            end else if (ALUOutE[31:2] == AOut[31:2]) begin
                if (out_m.size() < FD) opush = 1;
                else oset = 1;
            end else if (ALUOutE[31:2] == ASt[31:2]) begin
                oclr = WriteDataE[4];
                uclr = WriteDataE[5];
            end
        end
        if (ip) void'(in_m.pop_front());
        if (ipush) in_m.push_back(in_data);
        if (op) void'(out_m.pop_front());
        if (opush) out_m.push_back(WriteDataE[SW-1:0]);
        ovf_m = oset | (ovf_m & !oclr);
        und_m = uset | (und_m & !uclr);
    endtask

    task automatic tick();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
        if (rst_seen) begin
            exp_rdm = '0;
            rst_seen = 1'b0;
        end else if (rd_q.size() != 0) begin
            exp_rdm = rd_q.pop_front();
        end
        check_eq("ReadDataM", ReadDataM, exp_rdm);
    endtask

    task automatic ld(input logic [31:0] a);
        MemReadE = 1'b1; MemWriteE = 1'b0; ALUOutE = a;
        tick();
        MemReadE = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        MemWriteE = 1'b1; MemReadE = 1'b0; ALUOutE = a; WriteDataE = d;
        tick();
        MemWriteE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        reset = 1'b1; MemWriteE = 1'b0; MemReadE = 1'b0; ALUOutE = '0; WriteDataE = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        tick();
        check_eq("rst_rdm", ReadDataM, 32'h0);
        check_eq("rst_in_ready", in_ready, 1'b0);
        reset = 1'b0;
        #1;
        check_eq("rel_in_ready", in_ready, 1'b1);
        ld(ASt);
        check_eq("rst_status", ReadDataM, 32'h0000_0005);

        // RAM: store then load, load-before-store ordering, dual strobe, unmapped
        st(32'h10, 32'hDEAD_BEEF);
        ld(32'h10);
        check_eq("ram_rd", ReadDataM, 32'hDEAD_BEEF);
        st(32'h10, 32'h0000_1234);
        ld(32'h10);
        check_eq("ram_rd2", ReadDataM, 32'h0000_1234);
        st(32'h3FC, 32'hA5A5_0001);
        ld(32'h10);
        st(32'h10, 32'h0000_7777);
        check_eq("ld_old", ReadDataM, 32'h0000_1234);
        MemWriteE = 1'b1; MemReadE = 1'b1; ALUOutE = 32'h10; WriteDataE = 32'h5555_5555;
        tick();
        MemWriteE = 1'b0; MemReadE = 1'b0;
        check_eq("dual_hold", ReadDataM, 32'h0000_1234);
        ld(32'h10);
        check_eq("dual_wr", ReadDataM, 32'h5555_5555);
        ld(32'h3FC);
        ld(32'h2000_0000);
        check_eq("unmapped", ReadDataM, 32'h0);
        ld(AOut);

        // Input FIFO: signed samples, underflow sticky, no pop without MemReadE
        in_valid = 1'b1; in_data = 16'h8001; tick();
        in_data = 16'h0002; tick();
        in_valid = 1'b0;
        ALUOutE = AIn; idle(2);
        st(AIn, 32'h0);
        ld(AIn);
        check_eq("in_pop0", ReadDataM, 32'hFFFF_8001);
        ld(AIn);
        check_eq("in_pop1", ReadDataM, 32'h0000_0002);
        ld(AIn);
        check_eq("in_under", ReadDataM, 32'h0);
        ld(ASt);
        check_eq("und_bit", ReadDataM[5], 1'b1);
        st(ASt, 32'h20);
        ld(ASt);
        check_eq("und_clr", ReadDataM[5], 1'b0);

        // Output FIFO: fill, overflow, clear, stall, drain
        for (int i = 0; i < 16; i++) st(AOut, 32'hFFFF_0100 + i);
        st(AOut, 32'h999);
        ld(ASt);
        check_eq("ovf_bit", ReadDataM[4], 1'b1);
        check_eq("out_cnt", ReadDataM[23:16], 8'd16);
        check_eq("out_full", ReadDataM[3], 1'b1);
        st(ASt, 32'h10);
        ld(ASt);
        check_eq("ovf_clr", ReadDataM[4], 1'b0);
        idle(3);
        out_ready = 1'b1;
        st(AOut, 32'h0BAD);
        out_ready = 1'b0;
        ld(ASt);
        check_eq("ovf_pop", ReadDataM[4], 1'b1);
        idle(3);
        out_ready = 1'b1;
        idle(17);
        out_ready = 1'b0;
        check_eq("drained", out_valid, 1'b0);

        // Input full with a simultaneous load: order kept, push resumes next cycle
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 16'h0100 + 16'(i);
            tick();
        end
        in_data = 16'h0AAA;
        tick();
        ld(AIn);
        check_eq("full_pop", ReadDataM, 32'h0000_0100);
        check_eq("in_ready_back", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) ld(AIn);
        check_eq("last_in", ReadDataM, 32'h0000_0AAA);

        // Reset with both FIFOs half full and handshakes in flight
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 16'h7000 + 16'(i);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) st(AOut, 32'h0000_3000 + i);
        ld(ASt);
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check_eq("rst2_rdm", ReadDataM, 32'h0);
        check_eq("rst2_ovalid", out_valid, 1'b0);
        ld(ASt);
        check_eq("rst2_status", ReadDataM, 32'h0000_0005);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
